// File: rtl/uart_pkg.sv
// Shared state encodings, abort codes and checksum helper for the UART frame parser.
package uart_pkg;

  typedef enum logic [2:0] {
    S_HUNT = 3'd0,
    S_LEN  = 3'd1,
    S_PAY  = 3'd2,
    S_CHK  = 3'd3,
    S_OUT  = 3'd4
  } state_t;

  localparam logic [1:0] ERR_LEN  = 2'd0;
  localparam logic [1:0] ERR_CHK  = 2'd1;
  localparam logic [1:0] ERR_TMO  = 2'd2;
  localparam logic [1:0] ERR_LINE = 2'd3;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

  // Running frame checksum: XOR over LEN and every payload byte.
  function automatic logic [7:0] chk_update(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/uart_rx_frame_parser_if.sv
// Byte-stream bundle: UART receiver bytes in, verified payload stream out.
interface uart_rx_frame_parser_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       framing_error;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       m_last;

  modport slave (
    input  rx_data, rx_valid, framing_error, m_ready,
    output m_data, m_valid, m_last
  );

  modport master (
    output rx_data, rx_valid, framing_error, m_ready,
    input  m_data, m_valid, m_last
  );
endinterface

// File: rtl/uart_rx_frame_parser.sv
// Parses SOF|LEN|PAYLOAD|CHK frames from a UART byte stream and releases the
// buffered payload as a valid/ready stream once the XOR checksum matches.
module uart_rx_frame_parser
  import uart_pkg::*;
#(
  parameter logic [7:0]  SOF_BYTE     = SOF_DEFAULT,
  parameter int unsigned MAX_LEN      = 32'd16,
  parameter int unsigned TIMEOUT_CLKS = 32'd50000
) (
  input  logic                  clk,
  input  logic                  rst,
  uart_rx_frame_parser_if.slave bus,
  output logic                  frame_err,
  output logic [1:0]            err_code,
  output logic                  rx_overrun
);

  localparam int unsigned IDX_W     = $clog2(MAX_LEN + 32'd1);
  localparam int unsigned IDLE_W    = $clog2(TIMEOUT_CLKS + 32'd1);
  localparam int unsigned BUF_AW    = (MAX_LEN > 32'd1) ? $clog2(MAX_LEN) : 32'd1;
  localparam int unsigned BUF_DEPTH = 32'd1 << BUF_AW;

  localparam logic [IDX_W-1:0]  IDX_ONE    = IDX_W'(1);
  localparam logic [IDLE_W-1:0] IDLE_ONE   = IDLE_W'(1);
  localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT_CLKS);
  localparam logic [7:0]        MAX_LEN_B  = 8'(MAX_LEN);
  localparam logic [BUF_AW-1:0] BUF_ZERO   = {BUF_AW{1'b0}};

  state_t             state_r, state_n;
  logic [IDX_W-1:0]   len_r, len_n, idx_r, idx_n, rd_r, rd_n;
  logic [7:0]         chk_r, chk_n;
  logic [IDLE_W-1:0]  idle_r, idle_n, idle_inc;
  logic [7:0]         buf_r [BUF_DEPTH];
  logic               buf_we;
  logic               in_frame, good, line_bad, tmo;
  logic               abort;
  logic [1:0]         abort_code;
  logic               m_valid_r, m_valid_n, m_last_r, m_last_n;
  logic [7:0]         m_data_r, m_data_n;
  logic               frame_err_r, overrun_r, overrun_n;
  logic [1:0]         err_code_r, err_code_n;

  assign bus.m_valid = m_valid_r;
  assign bus.m_data  = m_data_r;
  assign bus.m_last  = m_last_r;
  assign frame_err   = frame_err_r;
  assign err_code    = err_code_r;
  assign rx_overrun  = overrun_r;

  // Next-state, datapath and next-output decode.
  always_comb begin
    state_n    = state_r;
    len_n      = len_r;
    idx_n      = idx_r;
    rd_n       = rd_r;
    chk_n      = chk_r;
    buf_we     = 1'b0;
    abort      = 1'b0;
    abort_code = ERR_LEN;
    m_valid_n  = 1'b0;
    m_data_n   = 8'h00;
    m_last_n   = 1'b0;
    overrun_n  = 1'b0;
    idle_inc   = (idle_r == IDLE_LIMIT) ? idle_r : idle_r + IDLE_ONE;
    in_frame   = (state_r == S_LEN) || (state_r == S_PAY) || (state_r == S_CHK);
    good       = bus.rx_valid && !bus.framing_error;
    line_bad   = bus.rx_valid && bus.framing_error;
    tmo        = !bus.rx_valid && (idle_inc == IDLE_LIMIT);

    if (in_frame && !bus.rx_valid) begin
      idle_n = idle_inc;
    end else begin
      idle_n = '0;
    end

    // Line errors and timeouts take priority over whatever the frame state expects.
    if (in_frame && line_bad) begin
      abort      = 1'b1;
      abort_code = ERR_LINE;
    end else if (in_frame && tmo) begin
      abort      = 1'b1;
      abort_code = ERR_TMO;
    end else begin
      case (state_r)
        S_HUNT: begin
          if (good && (bus.rx_data == SOF_BYTE)) begin
            state_n = S_LEN;
            chk_n   = 8'h00;
          end else begin
            state_n = S_HUNT;
          end
        end
        S_LEN: begin
          if (good && ((bus.rx_data == 8'h00) || (bus.rx_data > MAX_LEN_B))) begin
            abort      = 1'b1;
            abort_code = ERR_LEN;
          end else if (good) begin
            len_n   = bus.rx_data[IDX_W-1:0];
            idx_n   = '0;
            chk_n   = bus.rx_data;
            state_n = S_PAY;
          end else begin
            state_n = S_LEN;
          end
        end
        S_PAY: begin
          if (good) begin
            buf_we = 1'b1;
            chk_n  = chk_update(chk_r, bus.rx_data);
            idx_n  = idx_r + IDX_ONE;
            if ((idx_r + IDX_ONE) == len_r) begin
              state_n = S_CHK;
            end else begin
              state_n = S_PAY;
            end
          end else begin
            state_n = S_PAY;
          end
        end
        S_CHK: begin
          if (good && (bus.rx_data == chk_r)) begin
            state_n   = S_OUT;
            rd_n      = '0;
            m_valid_n = 1'b1;
            m_data_n  = buf_r[BUF_ZERO];
            m_last_n  = (len_r == IDX_ONE);
          end else if (good) begin
            abort      = 1'b1;
            abort_code = ERR_CHK;
          end else begin
            state_n = S_CHK;
          end
        end
        S_OUT: begin
          overrun_n = bus.rx_valid;
          m_valid_n = 1'b1;
          m_data_n  = m_data_r;
          m_last_n  = m_last_r;
          if (m_valid_r && bus.m_ready && m_last_r) begin
            state_n   = S_HUNT;
            m_valid_n = 1'b0;
            m_data_n  = 8'h00;
            m_last_n  = 1'b0;
          end else if (m_valid_r && bus.m_ready) begin
            rd_n     = rd_r + IDX_ONE;
            m_data_n = buf_r[rd_n[BUF_AW-1:0]];
            m_last_n = ((rd_n + IDX_ONE) == len_r);
          end else begin
            state_n = S_OUT;
          end
        end
        default: begin
          state_n = S_HUNT;
        end
      endcase
    end

    if (abort) begin
      state_n    = S_HUNT;
      err_code_n = abort_code;
    end else begin
      err_code_n = err_code_r;
    end
  end

  // Control state, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= S_HUNT;
      len_r       <= '0;
      idx_r       <= '0;
      rd_r        <= '0;
      chk_r       <= 8'h00;
      idle_r      <= '0;
      m_valid_r   <= 1'b0;
      m_data_r    <= 8'h00;
      m_last_r    <= 1'b0;
      frame_err_r <= 1'b0;
      err_code_r  <= 2'd0;
      overrun_r   <= 1'b0;
    end else begin
      state_r     <= state_n;
      len_r       <= len_n;
      idx_r       <= idx_n;
      rd_r        <= rd_n;
      chk_r       <= chk_n;
      idle_r      <= idle_n;
      m_valid_r   <= m_valid_n;
      m_data_r    <= m_data_n;
      m_last_r    <= m_last_n;
      frame_err_r <= abort;
      err_code_r  <= err_code_n;
      overrun_r   <= overrun_n;
    end
  end

  // Payload buffer, written in arrival order while collecting a frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_r <= '{default: 8'h00};
    end else if (buf_we) begin
      buf_r[idx_r[BUF_AW-1:0]] <= bus.rx_data;
    end else begin
      buf_r <= buf_r;
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_parser.sv
// Self-checking bench: frame-level reference model compared every cycle, plus
// hand-computed expectations for the directed scenarios.
module tb_uart_rx_frame_parser;
  import uart_pkg::*;

  localparam int         MAXL = 16;
  localparam int         TMO  = 40;
  localparam logic [7:0] SOF  = 8'hA5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_err;
  logic [1:0] err_code;
  logic       rx_overrun;
  int         checks = 0;
  int         failures = 0;

  uart_rx_frame_parser_if bus();

  uart_rx_frame_parser #(.SOF_BYTE(SOF), .MAX_LEN(MAXL), .TIMEOUT_CLKS(TMO)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .frame_err(frame_err), .err_code(err_code), .rx_overrun(rx_overrun)
  );

  always #5 clk = ~clk;

  // Reference model state: frame bytes after SOF, payload still to deliver.
  logic [7:0] frm[$];
  logic [7:0] out_q[$];
  bit         collecting;
  int         quiet;
  logic       exp_ferr, exp_ovr;
  logic [1:0] exp_code;

  // Observations of the DUT used by the directed checks.
  logic [7:0] acc_log[$];
  bit         last_log[$];
  int         acc_cyc[$];
  int         ferr_cnt = 0, ovr_cnt = 0, valid_cyc = 0, cyc = 0;
  logic [7:0] sq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic logic [7:0] log_at(input int i);
    return (i < acc_log.size()) ? acc_log[i] : 8'hxx;
  endfunction

  function automatic logic last_at(input int i);
    return (i < last_log.size()) ? last_log[i] : 1'bx;
  endfunction

  function automatic int cyc_at(input int i);
    return (i < acc_cyc.size()) ? acc_cyc[i] : -1000;
  endfunction

  task automatic model_abort(input logic [1:0] code);
    collecting = 1'b0;
    frm.delete();
    exp_ferr = 1'b1;
    exp_code = code;
  endtask

  // Advance the frame-level model by one clock using the inputs about to be sampled.
  task automatic model_step(input logic v, input logic [7:0] d, input logic fe, input logic rdy);
    logic [7:0] x;
    exp_ferr = 1'b0;
    exp_ovr  = 1'b0;
    if (out_q.size() > 0) begin
      if (v) exp_ovr = 1'b1;
      if (rdy) void'(out_q.pop_front());
    end else if (!collecting) begin
      if (v && !fe && d == SOF) begin
        collecting = 1'b1;
        frm.delete();
        quiet = 0;
      end
    end else if (v) begin
      quiet = 0;
      if (fe) begin
        model_abort(ERR_LINE);
      end else begin
        frm.push_back(d);
        if (frm.size() == 1 && (d == 8'h00 || int'(d) > MAXL)) begin
          model_abort(ERR_LEN);
        end else if (frm.size() > 1 && frm.size() == int'(frm[0]) + 2) begin
          x = 8'h00;
          for (int i = 0; i < frm.size() - 1; i++) x = x ^ frm[i];
          if (x == d) begin
            for (int i = 1; i < frm.size() - 1; i++) out_q.push_back(frm[i]);
            collecting = 1'b0;
            frm.delete();
          end else begin
            model_abort(ERR_CHK);
          end
        end
      end
    end else begin
      quiet++;
      if (quiet == TMO) model_abort(ERR_TMO);
    end
  endtask

  // Compare process: checks the DUT against the model on every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        chk("rst_m_valid", bus.m_valid, 1'b0);
        chk("rst_m_data", bus.m_data, 8'h00);
        chk("rst_m_last", bus.m_last, 1'b0);
        chk("rst_frame_err", frame_err, 1'b0);
        chk("rst_err_code", err_code, 2'd0);
        chk("rst_rx_overrun", rx_overrun, 1'b0);
        frm.delete();
        out_q.delete();
        collecting = 1'b0;
        quiet = 0;
        exp_ferr = 1'b0;
        exp_ovr = 1'b0;
        exp_code = 2'd0;
      end else begin
        chk("m_valid", bus.m_valid, out_q.size() > 0);
        if (out_q.size() > 0) begin
          chk("m_data", bus.m_data, out_q[0]);
          chk("m_last", bus.m_last, out_q.size() == 1);
        end
        chk("frame_err", frame_err, exp_ferr);
        chk("err_code", err_code, exp_code);
        chk("rx_overrun", rx_overrun, exp_ovr);
        if (bus.m_valid) valid_cyc++;
        if (bus.m_valid && bus.m_ready) begin
          acc_log.push_back(bus.m_data);
          last_log.push_back(bus.m_last);
          acc_cyc.push_back(cyc);
        end
        if (frame_err) ferr_cnt++;
        if (rx_overrun) ovr_cnt++;
        model_step(bus.rx_valid, bus.rx_data, bus.framing_error, bus.m_ready);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] d, input logic fe);
    bus.rx_data = d;
    bus.framing_error = fe;
    bus.rx_valid = 1'b1;
    tick(1);
    bus.rx_valid = 1'b0;
    bus.framing_error = 1'b0;
    bus.rx_data = 8'h00;
  endtask

  task automatic send_all(input int gap);
    foreach (sq[i]) begin
      send(sq[i], 1'b0);
      if (gap > 0) tick(gap);
    end
  endtask

  initial begin
    int base, f0, v0, o0;
    bus.rx_data = 8'h00;
    bus.rx_valid = 1'b0;
    bus.framing_error = 1'b0;
    bus.m_ready = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(2);

    // 1: good 3-byte frame, streamed back to back.
    base = acc_log.size(); f0 = ferr_cnt;
    sq = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
    send_all(1);
    tick(8);
    chk("t1_count", acc_log.size() - base, 3);
    chk("t1_b0", log_at(base), 8'h11);
    chk("t1_b1", log_at(base + 1), 8'h22);
    chk("t1_b2", log_at(base + 2), 8'h33);
    chk("t1_last_mid", last_at(base + 1), 1'b0);
    chk("t1_last_end", last_at(base + 2), 1'b1);
    chk("t1_consecutive", cyc_at(base + 2) - cyc_at(base), 2);
    chk("t1_no_err", ferr_cnt - f0, 0);

    // 2: checksum mismatch, then a good frame is still accepted.
    f0 = ferr_cnt; v0 = valid_cyc; base = acc_log.size();
    sq = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h04};
    send_all(1);
    tick(4);
    chk("t2_ferr", ferr_cnt - f0, 1);
    chk("t2_code", err_code, ERR_CHK);
    chk("t2_no_valid", valid_cyc - v0, 0);
    sq = '{8'hA5, 8'h02, 8'h0F, 8'hF0, 8'hFD};
    send_all(1);
    tick(6);
    chk("t2_good_count", acc_log.size() - base, 2);
    chk("t2_good_b0", log_at(base), 8'h0F);
    chk("t2_good_b1", log_at(base + 1), 8'hF0);

    // 3: LEN 0 and LEN 17 rejected; LEN 16 and LEN 1 accepted.
    f0 = ferr_cnt;
    sq = '{8'hA5, 8'h00};
    send_all(1);
    tick(2);
    sq = '{8'hA5, 8'h11};
    send_all(1);
    tick(3);
    chk("t3_ferr", ferr_cnt - f0, 2);
    chk("t3_code", err_code, ERR_LEN);
    base = acc_log.size();
    sq = '{8'hA5, 8'h10};
    for (int i = 1; i <= 16; i++) sq.push_back(8'(i));
    sq.push_back(8'h00);
    send_all(1);
    tick(20);
    chk("t3_max_count", acc_log.size() - base, 16);
    chk("t3_max_lastb", log_at(base + 15), 8'h10);
    chk("t3_max_lastf", last_at(base + 15), 1'b1);
    base = acc_log.size();
    sq = '{8'hA5, 8'h01, 8'h5C, 8'h5D};
    send_all(1);
    tick(4);
    chk("t3_one_count", acc_log.size() - base, 1);
    chk("t3_one_b0", log_at(base), 8'h5C);
    chk("t3_one_last", last_at(base), 1'b1);

    // 4: timeout after TMO idle clocks; TMO-1 idle clocks is tolerated.
    f0 = ferr_cnt;
    sq = '{8'hA5, 8'h02, 8'h7E};
    send_all(0);
    tick(TMO + 3);
    chk("t4_ferr", ferr_cnt - f0, 1);
    chk("t4_code", err_code, ERR_TMO);
    f0 = ferr_cnt; base = acc_log.size();
    send(8'hA5, 1'b0);
    send(8'h01, 1'b0);
    tick(TMO - 1);
    send(8'h33, 1'b0);
    send(8'h32, 1'b0);
    tick(4);
    chk("t4_edge_no_err", ferr_cnt - f0, 0);
    chk("t4_edge_b0", log_at(base), 8'h33);

    // 5: line error mid-frame; garbage in hunt is silent; aborting byte is not a new SOF.
    f0 = ferr_cnt;
    sq = '{8'hA5, 8'h02};
    send_all(1);
    send(8'h44, 1'b1);
    tick(2);
    chk("t5_ferr", ferr_cnt - f0, 1);
    chk("t5_code", err_code, ERR_LINE);
    f0 = ferr_cnt;
    sq = '{8'h00, 8'hFF, 8'h5A};
    send_all(1);
    send(8'hA5, 1'b1);
    tick(TMO + 3);
    chk("t5_garbage_quiet", ferr_cnt - f0, 0);
    f0 = ferr_cnt; v0 = valid_cyc;
    sq = '{8'hA5, 8'h01, 8'h10, 8'hA5, 8'h01, 8'h10, 8'h11};
    send_all(1);
    tick(4);
    chk("t5_resync_ferr", ferr_cnt - f0, 1);
    chk("t5_resync_code", err_code, ERR_CHK);
    chk("t5_resync_novalid", valid_cyc - v0, 0);

    // 6: backpressure with an injected byte during output.
    f0 = ferr_cnt; o0 = ovr_cnt; base = acc_log.size();
    bus.m_ready = 1'b0;
    sq = '{8'hA5, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00};
    send_all(1);
    tick(2);
    send(8'h77, 1'b0);
    for (int i = 0; i < 10; i++) begin
      bus.m_ready = (i % 2 == 1);
      tick(1);
    end
    bus.m_ready = 1'b1;
    tick(3);
    chk("t6_count", acc_log.size() - base, 4);
    chk("t6_b0", log_at(base), 8'h01);
    chk("t6_b1", log_at(base + 1), 8'h02);
    chk("t6_b2", log_at(base + 2), 8'h03);
    chk("t6_b3", log_at(base + 3), 8'h04);
    chk("t6_last", last_at(base + 3), 1'b1);
    chk("t6_overrun", ovr_cnt - o0, 1);
    chk("t6_no_err", ferr_cnt - f0, 0);

    // Reset in the middle of a payload clears all outputs at once.
    sq = '{8'hA5, 8'h03, 8'h11};
    send_all(0);
    chk("pre_rst_code", err_code, ERR_CHK);
    rst = 1'b1;
    #1;
    chk("arst_m_valid", bus.m_valid, 1'b0);
    chk("arst_m_data", bus.m_data, 8'h00);
    chk("arst_m_last", bus.m_last, 1'b0);
    chk("arst_frame_err", frame_err, 1'b0);
    chk("arst_err_code", err_code, 2'd0);
    chk("arst_rx_overrun", rx_overrun, 1'b0);
    tick(2);
    rst = 1'b0;
    tick(1);
    base = acc_log.size(); f0 = ferr_cnt;
    sq = '{8'h22, 8'h33, 8'hA5, 8'h01, 8'h5C, 8'h5D};
    send_all(1);
    tick(4);
    chk("post_rst_count", acc_log.size() - base, 1);
    chk("post_rst_b0", log_at(base), 8'h5C);
    chk("post_rst_no_err", ferr_cnt - f0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
